branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 23 ++
 rtl/bp_ras.sv | 68 ++++++
 rtl/branch_predictor.sv | 68 ++++++
 tb/tb_branch_predictor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared decode constants and helpers for the fetch-stage branch predictor.
package bp_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [4:0] LINK_RA = 5'd1;
    localparam logic [4:0] LINK_T0 = 5'd5;

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_RA) || (r == LINK_T0);
    endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry, count saturates.
module bp_ras #(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    input  logic        flush,
    output logic [31:0] top,
    output logic        empty
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] sp_q, sp_d, top_idx, wr_idx;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     entries_q [RAS_DEPTH];
    logic            wr_en;
    logic            do_pop;

    // sp_q points at the next free slot; the top lives one below it.
    assign top_idx = sp_q - PtrW'(1);
    assign empty   = (cnt_q == '0);
    assign top     = entries_q[top_idx];
    assign do_pop  = pop && !empty;

    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = sp_q;
        if (flush) begin
            cnt_d = '0;
        end else if (push && do_pop) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            wr_en = 1'b1;
            sp_d  = sp_q + PtrW'(1);
            if (cnt_q != CntW'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (do_pop) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                entries_q[wr_idx] <= push_data;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Zero-latency next-fetch predictor: static JAL/branch targets plus an optional
// return-address stack for JALR returns.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RAS_EN    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] instr_addr,
    input  logic        update,
    input  logic        flush,
    output logic [31:0] next_addr
);

    localparam bit RasOn = (RAS_EN != 0);

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1;
    logic [31:0] pc4;
    logic        is_jal, is_jalr, is_branch;
    logic        pop_pred;
    logic        ras_push, ras_pop, ras_flush, ras_empty;
    logic [31:0] ras_top;

    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign rs1       = instr[19:15];
    assign pc4       = instr_addr + 32'd4;
    assign is_jal    = (instr[1:0] == 2'b11) && (opcode == OPC_JAL);
    assign is_jalr   = (instr[1:0] == 2'b11) && (opcode == OPC_JALR);
    assign is_branch = (instr[1:0] == 2'b11) && (opcode == OPC_BRANCH);
    assign pop_pred  = is_jalr && is_link(rs1) && (rd == 5'd0);

    // A JALR linking through one link register while returning through the other
    // both pops and pushes; the stack turns that into an in-place replace.
    assign ras_push  = RasOn && update && (is_jal || is_jalr) && is_link(rd);
    assign ras_pop   = RasOn && update && is_jalr && is_link(rs1) &&
                       ((rd == 5'd0) || (is_link(rd) && (rd != rs1)));
    assign ras_flush = RasOn && flush;

    bp_ras #(
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc4),
        .flush    (ras_flush),
        .top      (ras_top),
        .empty    (ras_empty)
    );

    always_comb begin
        next_addr = pc4;
        if (is_jal) begin
            next_addr = instr_addr + imm_j(instr);
        end else if (is_branch && instr[31]) begin
            next_addr = instr_addr + imm_b(instr);
        end else if (pop_pred && RasOn && !ras_empty) begin
            next_addr = ras_top;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: decode vectors, return-stack sequences and a randomized
// run against a queue-based stack model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0000_0013;
    logic [31:0] instr_addr = 32'h0;
    logic        update = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] next_ras, next_noras;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    branch_predictor #(.RAS_DEPTH(4), .RAS_EN(1)) dut_ras (
        .clk(clk), .rst(rst), .instr(instr), .instr_addr(instr_addr),
        .update(update), .flush(flush), .next_addr(next_ras)
    );

    branch_predictor #(.RAS_DEPTH(4), .RAS_EN(0)) dut_noras (
        .clk(clk), .rst(rst), .instr(instr), .instr_addr(instr_addr),
        .update(update), .flush(flush), .next_addr(next_noras)
    );

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic bit link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic [31:0] addr,
                         input logic upd, input logic fl);
        @(negedge clk);
        instr      = ins;
        instr_addr = addr;
        update     = upd;
        flush      = fl;
        #1;
    endtask

    task automatic pick_reg(output logic [4:0] r);
        case ($urandom_range(0, 3))
            0:       r = 5'd0;
            1:       r = 5'd1;
            2:       r = 5'd5;
            default: r = 5'($urandom_range(0, 31));
        endcase
    endtask

    task automatic run_random(input int n);
        logic [31:0] pc, ins, r, exp_ras;
        logic [20:0] ij;
        logic [12:0] ib;
        logic [11:0] ii;
        logic [4:0]  rd, rs1;
        int          kind;
        bit          push, pop, upd, fl;
        for (int k = 0; k < n; k++) begin
            pc   = $urandom & 32'hFFFF_FFFC;
            push = 0;
            pop  = 0;
            upd  = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    do begin
                        r = $urandom;
                        r[1:0] = 2'b11;
                    end while (r[6:0] == 7'b1101111 || r[6:0] == 7'b1100111 ||
                               r[6:0] == 7'b1100011);
                    ins = r;
                    exp_ras = pc + 32'd4;
                end
                1: begin
                    r = $urandom;
                    r[1:0] = 2'($urandom_range(0, 2));
                    ins = r;
                    exp_ras = pc + 32'd4;
                end
                2: begin
                    pick_reg(rd);
                    ij = 21'($urandom) & 21'h1F_FFFE;
                    ins = enc_jal(rd, ij);
                    exp_ras = pc + {{11{ij[20]}}, ij};
                    push = link(rd);
                end
                3: begin
                    ib = 13'($urandom) & 13'h1FFE;
                    ins = enc_br(3'($urandom_range(0, 7)), ib);
                    exp_ras = ib[12] ? pc + {{19{ib[12]}}, ib} : pc + 32'd4;
                end
                default: begin
                    pick_reg(rd);
                    pick_reg(rs1);
                    ii = 12'($urandom);
                    ins = enc_jalr(rd, rs1, ii);
                    exp_ras = (link(rs1) && rd == 5'd0 && model_q.size() > 0) ?
                              model_q[$] : pc + 32'd4;
                    push = link(rd);
                    pop  = link(rs1) && (rd == 5'd0 || (link(rd) && rd != rs1));
                end
            endcase
            apply(ins, pc, upd, fl);
            check("rand_ras", next_ras, exp_ras);
            if (kind == 2 || kind == 3) check("rand_noras", next_noras, exp_ras);
            else check("rand_noras", next_noras, pc + 32'd4);
            if (fl) begin
                model_q.delete();
            end else if (upd) begin
                if (push && pop && model_q.size() > 0) begin
                    model_q[model_q.size() - 1] = pc + 32'd4;
                end else if (push) begin
                    model_q.push_back(pc + 32'd4);
                    if (model_q.size() > 4) void'(model_q.pop_front());
                end else if (pop && model_q.size() > 0) begin
                    void'(model_q.pop_back());
                end
            end
        end
    endtask

    initial begin
        vec_t        vecs[9];
        logic [31:0] ret;

        vecs[0] = '{"jal_fwd",    enc_jal(5'd0, 21'h20),      32'h100,       32'h120};
        vecs[1] = '{"beq_back",   enc_br(3'b000, 13'h1FF8),   32'h200,       32'h1F8};
        vecs[2] = '{"bne_fwd",    enc_br(3'b001, 13'd16),     32'h200,       32'h204};
        vecs[3] = '{"jalr_empty", enc_jalr(5'd0, 5'd1, 12'd0), 32'h40,       32'h44};
        vecs[4] = '{"jal_wrap",   enc_jal(5'd0, 21'd8),       32'hFFFF_FFFC, 32'h4};
        vecs[5] = '{"compressed", 32'h0000_006D,              32'h10,        32'h14};
        vecs[6] = '{"jal_back",   enc_jal(5'd1, 21'h1F_FFFC), 32'h1000,      32'hFFC};
        vecs[7] = '{"addi",       32'h0000_0013,              32'h8,         32'hC};
        vecs[8] = '{"blt_wrap",   enc_br(3'b100, 13'h1000),   32'h0,         32'hFFFF_F000};

        // Reset state: empty stack, so a return predicts pc+4.
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h40, 1'b0, 1'b0);
        check("reset_pop", next_ras, 32'h44);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].ins, vecs[i].addr, 1'b0, 1'b0);
            check({vecs[i].name, "_ras"}, next_ras, vecs[i].exp);
            check({vecs[i].name, "_noras"}, next_noras, vecs[i].exp);
        end

        // Call then return.
        apply(enc_jal(5'd1, 21'h100), 32'h300, 1'b1, 1'b0);
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h500, 1'b1, 1'b0);
        check("ret_pred", next_ras, 32'h304);
        check("ret_noras", next_noras, 32'h504);
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h500, 1'b0, 1'b0);
        check("ret_after_pop", next_ras, 32'h504);

        // Overflow: five pushes into four entries.
        for (int k = 1; k <= 5; k++) apply(enc_jal(5'd1, 21'h40), 32'h1000 * k, 1'b1, 1'b0);
        for (int k = 5; k >= 1; k--) begin
            apply(enc_jalr(5'd0, 5'd5, 12'd0), 32'h8000, 1'b1, 1'b0);
            ret = (k >= 2) ? 32'h1000 * k + 32'd4 : 32'h8004;
            check($sformatf("ovf_pop%0d", 6 - k), next_ras, ret);
        end

        // Flush after two pushes.
        apply(enc_jal(5'd1, 21'h40), 32'h100, 1'b1, 1'b0);
        apply(enc_jal(5'd1, 21'h40), 32'h200, 1'b1, 1'b0);
        apply(32'h0000_0013, 32'h0, 1'b0, 1'b1);
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h600, 1'b0, 1'b0);
        check("flush_pop", next_ras, 32'h604);

        // Flush beats a simultaneous push.
        apply(enc_jal(5'd1, 21'h40), 32'h100, 1'b1, 1'b0);
        apply(enc_jal(5'd1, 21'h40), 32'h200, 1'b1, 1'b1);
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h600, 1'b0, 1'b0);
        check("flush_prio", next_ras, 32'h604);

        // Asynchronous reset pulse between edges after two pushes.
        apply(enc_jal(5'd1, 21'h40), 32'h100, 1'b1, 1'b0);
        apply(enc_jal(5'd1, 21'h40), 32'h200, 1'b1, 1'b0);
        @(negedge clk);
        update = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h600, 1'b0, 1'b0);
        check("rst_pop", next_ras, 32'h604);

        // Reset held across a push edge discards it.
        apply(enc_jal(5'd1, 21'h40), 32'h700, 1'b1, 1'b0);
        rst = 1'b1;
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h600, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_discard", next_ras, 32'h604);

        // Pop-and-push JALR replaces the top.
        apply(enc_jal(5'd1, 21'h40), 32'h100, 1'b1, 1'b0);
        apply(enc_jal(5'd1, 21'h40), 32'h200, 1'b1, 1'b0);
        apply(enc_jalr(5'd5, 5'd1, 12'd0), 32'h300, 1'b1, 1'b0);
        check("repl_pred", next_ras, 32'h304);
        apply(enc_jalr(5'd0, 5'd5, 12'd0), 32'h900, 1'b1, 1'b0);
        check("repl_top", next_ras, 32'h304);
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h900, 1'b1, 1'b0);
        check("repl_below", next_ras, 32'h104);
        apply(enc_jalr(5'd0, 5'd1, 12'd0), 32'h900, 1'b0, 1'b0);
        check("repl_empty", next_ras, 32'h904);

        apply(32'h0000_0013, 32'h0, 1'b0, 1'b1);
        model_q.delete();
        run_random(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
